freq_meas_sched: RTL and testbench

- Round-robin scheduler that time-shares one Schmitt-trigger and period-measurement path between NCH ADC channels.
- Drives the channel-select mux ahead of the shared trigger and waits a settle time after each switch.
- Measures AVG_N consecutive full periods on the trigger output, then presents a per-channel result over a valid/ready handshake.
- Sits between the ADC front-end mux and the host register bank / UART reporter.

---
 rtl/freq_meas_sched.sv | 206 ++++++++++++++++++++
 tb/tb_freq_meas_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin scheduler that time-shares one Schmitt-trigger
// period-measurement path between NCH channels and reports one result per
// enabled channel over a valid/ready handshake.
// Build option: define FREQ_SCHED_AVG_EN to report the mean period
// (sum >> LOG2_AVG) instead of the raw sum of AVG_N periods.
module freq_meas_sched #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CHW      = 2,
    parameter int unsigned LOG2_AVG = 3,
    parameter int unsigned SETTLE   = 64,
    parameter int unsigned TIMEOUT  = 32'd50_000_000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [NCH-1:0]          ch_en,
    input  logic                    trig_in,
    output logic [CHW-1:0]          ch_sel,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CHW-1:0]          res_ch,
    output logic [32+LOG2_AVG-1:0]  res_sum,
    output logic                    res_timeout
);
    localparam int unsigned SW    = 32 + LOG2_AVG;
    localparam int unsigned PW    = LOG2_AVG + 1;
    localparam int unsigned AVG_N = 1 << LOG2_AVG;

    typedef enum logic [2:0] {StIdle, StSettle, StArm, StMeas, StOut} state_e;

    state_e         state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d, mask_rem;
    logic [CHW-1:0] ch_sel_q, ch_sel_d;
    logic           busy_q, busy_d;
    logic [31:0]    settle_q, settle_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [SW-1:0]  sum_q, sum_d, sum_acc, sum_report;
    logic [PW-1:0]  per_q, per_d;
    logic           res_valid_q, res_valid_d;
    logic [CHW-1:0] res_ch_q, res_ch_d;
    logic [SW-1:0]  res_sum_q, res_sum_d;
    logic           res_to_q, res_to_d;
    logic           prev_q;
    logic           rise, cnt_expired;

    // Index of the lowest set bit; callers guarantee m != 0.
    function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [CHW-1:0] idx;
        logic           found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i] && !found) begin
                idx   = CHW'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign rise        = trig_in & ~prev_q;
    // Checked before the edge: a rise at TIMEOUT-1 is still a valid period.
    assign cnt_expired = (cnt_q == TIMEOUT - 1);
    assign sum_acc     = sum_q + SW'(cnt_q) + SW'(1);
    // Channels still to visit once the current one has been reported.
    assign mask_rem    = mask_q & ~(NCH'(1) << ch_sel_q);

    // Reported value of a completed measurement.
    always_comb begin
`ifdef FREQ_SCHED_AVG_EN
        sum_report = sum_acc >> LOG2_AVG;
`else
        sum_report = sum_acc;
`endif
    end

    // Next-state and datapath updates for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_sel_d    = ch_sel_q;
        busy_d      = busy_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        per_d       = per_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_sum_d   = res_sum_q;
        res_to_d    = res_to_q;
        unique case (state_q)
            StIdle: begin
                if (start && (ch_en != '0)) begin
                    mask_d   = ch_en;
                    busy_d   = 1'b1;
                    ch_sel_d = lowest_set(ch_en);
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == SETTLE - 1) begin
                    cnt_d   = '0;
                    state_d = StArm;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            StArm: begin
                if (rise) begin
                    cnt_d   = '0;
                    sum_d   = '0;
                    per_d   = '0;
                    state_d = StMeas;
                end else if (cnt_expired) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_sel_q;
                    res_sum_d   = '0;
                    res_to_d    = 1'b1;
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StMeas: begin
                if (rise) begin
                    sum_d = sum_acc;
                    cnt_d = '0;
                    per_d = per_q + 1'b1;
                    if (per_q == PW'(AVG_N - 1)) begin
                        res_valid_d = 1'b1;
                        res_ch_d    = ch_sel_q;
                        res_sum_d   = sum_report;
                        res_to_d    = 1'b0;
                        state_d     = StOut;
                    end
                end else if (cnt_expired) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_sel_q;
                    res_sum_d   = '0;
                    res_to_d    = 1'b1;
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StOut: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    mask_d      = mask_rem;
                    if (mask_rem != '0) begin
                        ch_sel_d = lowest_set(mask_rem);
                        settle_d = '0;
                        state_d  = StSettle;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any sweep in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            ch_sel_q    <= '0;
            busy_q      <= 1'b0;
            settle_q    <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            per_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_sum_q   <= '0;
            res_to_q    <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_sel_q    <= ch_sel_d;
            busy_q      <= busy_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            per_q       <= per_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_sum_q   <= res_sum_d;
            res_to_q    <= res_to_d;
            prev_q      <= trig_in;
        end
    end

    assign ch_sel      = ch_sel_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_sum     = res_sum_q;
    assign res_timeout = res_to_q;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Self-checking bench for freq_meas_sched: directed sweep table, hand-timed
// settle/timeout sequences, reset and ignored-start cases, random sweeps.
module tb_freq_meas_sched;
    localparam int NCH = 4;
    localparam int LA  = 3;
    localparam int AVG = 8;
    localparam int SET = 64;
    localparam int TO  = 1000;
    localparam int SW  = 32 + LA;

    logic          clk, rstn, start, trig_in, busy, res_valid, res_ready, res_timeout;
    logic [3:0]    ch_en;
    logic [1:0]    ch_sel, res_ch;
    logic [SW-1:0] res_sum;

    freq_meas_sched #(
        .NCH(NCH), .CHW(2), .LOG2_AVG(LA), .SETTLE(SET), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .ch_en(ch_en), .trig_in(trig_in),
        .ch_sel(ch_sel), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_sum(res_sum), .res_timeout(res_timeout)
    );

    typedef struct packed {
        logic [1:0]    ch;
        logic          to;
        logic [SW-1:0] sum;
    } res_t;

    typedef struct packed {
        logic [3:0]       en;
        logic [3:0][15:0] per;
        logic [3:0][15:0] exp_sum;
        logic [3:0]       exp_to;
        logic [1:0]       rdy;
    } vec_t;

    res_t exp_q[$];
    int   cur_per[4];
    bit   manual;
    int   t;
    int   checks, errors;
    int   tag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square wave of the selected channel's period; rises when t % p == 0.
    initial begin
        int p;
        t       = 0;
        trig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            t++;
            if (!manual) begin
                p = cur_per[ch_sel];
                if (p >= 2) trig_in = ((t % p) < (p / 2));
                else        trig_in = 1'b0;
            end
        end
    end

    function automatic logic [SW-1:0] scale(input logic [SW-1:0] raw);
`ifdef FREQ_SCHED_AVG_EN
        return raw >> LA;
`else
        return raw;
`endif
    endfunction

    // Reference: a steady wave of period p yields AVG periods of p, unless no
    // rise can arrive within TO cycles.
    function automatic res_t model(input int c, input int p);
        res_t r;
        r.ch = 2'(c);
        if (p < 2 || p > TO) begin
            r.to  = 1'b1;
            r.sum = '0;
        end else begin
            r.to  = 1'b0;
            r.sum = scale(SW'(p * AVG));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (case %0d): got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    // Start a sweep and consume results; rdy 0=always ready, 1=random, 2=hold 500.
    task automatic run_sweep(input logic [3:0] en, input int rdy, input bit extra);
        int         k, got, hold, n;
        logic [1:0] last_ch;
        res_t       e;
        start = 1'b1;
        ch_en = en;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ch_en   = 4'($urandom);
        n       = exp_q.size();
        got     = 0;
        hold    = 0;
        k       = 0;
        last_ch = 2'd0;
        while (got < n && k < 30000) begin
            case (rdy)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom);
                default: res_ready = (hold >= 500);
            endcase
            if (extra && k == 20) begin
                start = 1'b1;
                ch_en = 4'b1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0) chk("busy_after_start", busy, 1);
            if (res_valid) begin
                e = exp_q[0];
                chk("res_ch", res_ch, e.ch);
                chk("res_timeout", res_timeout, e.to);
                chk("res_sum", res_sum, e.sum);
                chk("ch_sel_in_out", ch_sel, e.ch);
                hold++;
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    last_ch = e.ch;
                    got++;
                    hold = 0;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        res_ready = 1'b0;
        start     = 1'b0;
        if (got < n) chk("sweep_results", got, n);
        @(negedge clk);
        chk("busy_after_sweep", busy, 0);
        chk("valid_after_sweep", res_valid, 0);
        chk("ch_sel_holds_last", ch_sel, last_ch);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] en, input int p0, input int p1, input int p2,
                                input int p3, input int s0, input int s1, input int s2,
                                input int s3, input logic [3:0] to, input int rdy);
        vec_t v;
        v.en         = en;
        v.per[0]     = 16'(p0);
        v.per[1]     = 16'(p1);
        v.per[2]     = 16'(p2);
        v.per[3]     = 16'(p3);
        v.exp_sum[0] = 16'(s0);
        v.exp_sum[1] = 16'(s1);
        v.exp_sum[2] = 16'(s2);
        v.exp_sum[3] = 16'(s3);
        v.exp_to     = to;
        v.rdy        = 2'(rdy);
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        res_t r;
        int   first;
        bit   saw;
        checks    = 0;
        errors    = 0;
        tag       = 0;
        manual    = 1'b0;
        rstn      = 1'b0;
        start     = 1'b0;
        ch_en     = 4'b0;
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) cur_per[c] = 0;

        tbl[0] = mk(4'b0001, 100, 0, 0, 0,     800, 0, 0, 0,       4'b0000, 0);
        tbl[1] = mk(4'b1010, 0, 50, 0, 200,    0, 400, 0, 1600,    4'b0000, 0);
        tbl[2] = mk(4'b0100, 0, 0, 0, 0,       0, 0, 0, 0,         4'b0100, 0);
        tbl[3] = mk(4'b1111, 2, 1000, 1001, 37, 16, 8000, 0, 296,  4'b0100, 1);
        tbl[4] = mk(4'b1001, 7, 0, 0, 999,     56, 0, 0, 7992,     4'b0000, 1);
        tbl[5] = mk(4'b0001, 100, 0, 0, 0,     800, 0, 0, 0,       4'b0000, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ch_sel", ch_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", res_valid, 0);
        chk("reset_sum", res_sum, 0);
        chk("reset_timeout", res_timeout, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed sweeps; case 1 also issues a start while busy.
        for (int i = 0; i < 6; i++) begin
            tag = i;
            for (int c = 0; c < 4; c++) cur_per[c] = int'(tbl[i].per[c]);
            exp_q.delete();
            for (int c = 0; c < 4; c++) begin
                if (tbl[i].en[c]) begin
                    r.ch  = 2'(c);
                    r.to  = tbl[i].exp_to[c];
                    r.sum = scale(SW'(tbl[i].exp_sum[c]));
                    exp_q.push_back(r);
                end
            end
            run_sweep(tbl[i].en, int'(tbl[i].rdy), (i == 1));
        end

        // start with an empty mask is ignored.
        tag   = 10;
        start = 1'b1;
        ch_en = 4'b0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || res_valid) saw = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("zero_en_idle", saw, 0);

        // Hand-timed: a pulse in the last settle cycle must be ignored.
        tag    = 11;
        manual = 1'b1;
        trig_in = 1'b0;
        start  = 1'b1;
        ch_en  = 4'b0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = -1;
        for (int k = 0; k < 400 && first < 0; k++) begin
            trig_in = (k == SET - 1) || (k >= 73 && ((k - 73) % 10) == 0);
            @(negedge clk);
            if (k == 0) chk("busy_manual", busy, 1);
            if (res_valid) first = k;
            @(posedge clk);
            #1;
        end
        trig_in = 1'b0;
        chk("settle_latency", first, 154);
        chk("settle_sum", res_sum, scale(SW'(80)));
        chk("settle_ch", res_ch, 1);
        chk("settle_to", res_timeout, 0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("settle_valid_hold", res_valid, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("settle_done_busy", busy, 0);
        @(posedge clk);
        #1;

        // Hand-timed: stuck input times out exactly TO cycles after ARM.
        tag   = 12;
        start = 1'b1;
        ch_en = 4'b0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = -1;
        for (int k = 0; k < 1500 && first < 0; k++) begin
            @(negedge clk);
            if (res_valid) first = k;
            @(posedge clk);
            #1;
        end
        chk("timeout_latency", first, SET + TO);
        chk("timeout_flag", res_timeout, 1);
        chk("timeout_sum", res_sum, 0);
        chk("timeout_ch", res_ch, 2);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("timeout_done_busy", busy, 0);
        @(posedge clk);
        #1;
        manual = 1'b0;

        // Reset during MEAS, then a fresh sweep.
        tag        = 13;
        cur_per[1] = 100;
        start      = 1'b1;
        ch_en      = 4'b0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_ch_sel", ch_sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_ch", res_ch, 0);
        chk("midrst_sum", res_sum, 0);
        chk("midrst_to", res_timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        saw  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || res_valid) saw = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_rst_idle", saw, 0);
        exp_q.delete();
        exp_q.push_back(model(1, 100));
        run_sweep(4'b0010, 0, 1'b0);

        // Random sweeps against the reference model.
        for (int i = 0; i < 5; i++) begin
            logic [3:0] en;
            tag = 20 + i;
            en  = 4'($urandom_range(1, 15));
            exp_q.delete();
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 9) == 0) cur_per[c] = 0;
                else                           cur_per[c] = $urandom_range(2, 120);
                if (en[c]) exp_q.push_back(model(c, cur_per[c]));
            end
            run_sweep(en, 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
